// File: rtl/execute_stage_md_if.sv
// execute_stage_md_if: EX/MEM pipeline-register bus between the execute and memory stages.
//   master (execute stage) drives: RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM
//   slave  (memory stage) receives the same signals.
interface execute_stage_md_if #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
);
    logic             RegWriteM;
    logic             MemWriteM;
    logic             ResultSrcM;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [WIDTH-1:0] PCPlus4M;
    logic [RADDR-1:0] RdM;
    modport master (output RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM);
    modport slave  (input  RegWriteM, MemWriteM, ResultSrcM, ALUResultM, WriteDataM, PCPlus4M, RdM);
endinterface

// File: rtl/execute_stage_md.sv
// execute_stage_md: pipeline execute stage with operand forwarding, RV32I ALU, branch resolution
//   and an iterative MUL/DIV/REM unit; owns the EX/MEM register.
//   clk, rst (async, active low)
//   ID/EX in : RegWriteE MemWriteE ResultSrcE ALUSrcE BranchE JumpE ALUControlE Funct3E
//              RD1E RD2E PCE PCPlus4E ImmExtE RdE
//   hazard in: ForwardAE ForwardBE ResultW KillE
//   out      : PCSrcE PCTargetE stallE
//   exMem    : EX/MEM register bus (master)
module execute_stage_md #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RegWriteE,
    input  logic               MemWriteE,
    input  logic               ResultSrcE,
    input  logic               ALUSrcE,
    input  logic               BranchE,
    input  logic               JumpE,
    input  logic [3:0]         ALUControlE,
    input  logic [2:0]         Funct3E,
    input  logic [WIDTH-1:0]   RD1E,
    input  logic [WIDTH-1:0]   RD2E,
    input  logic [WIDTH-1:0]   PCE,
    input  logic [WIDTH-1:0]   PCPlus4E,
    input  logic [WIDTH-1:0]   ImmExtE,
    input  logic [RADDR-1:0]   RdE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [WIDTH-1:0]   ResultW,
    input  logic               KillE,
    output logic               PCSrcE,
    output logic [WIDTH-1:0]   PCTargetE,
    output logic               stallE,
    execute_stage_md_if.master exMem
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, nextState;
    logic [WIDTH-1:0] fwdA, fwdB, srcB, aluOut, mdOut, absA, absB;
    logic [WIDTH-1:0] opA, opB, acc, opAN, opBN, accN, mulSum, quot, remv;
    logic [WIDTH:0]   remShift, remDiff;
    logic [CW-1:0]    shamt, cnt;
    logic [3:0]       mdOp;
    logic             negQ, negR, divZero, isMdE, isMulE, isSigned, start, geq, eq, lt, ltu, cond, bubble;

    assign fwdA = ForwardAE == 2'b01 ? ResultW : ForwardAE == 2'b10 ? exMem.ALUResultM : RD1E;
    assign fwdB = ForwardBE == 2'b01 ? ResultW : ForwardBE == 2'b10 ? exMem.ALUResultM : RD2E;
    assign srcB = ALUSrcE ? ImmExtE : fwdB;
    assign shamt = srcB[CW-1:0];

    always_comb begin
        aluOut = '0;
        case (ALUControlE)
            4'b0000: aluOut = fwdA + srcB;
            4'b0001: aluOut = fwdA - srcB;
            4'b0010: aluOut = fwdA & srcB;
            4'b0011: aluOut = fwdA | srcB;
            4'b0100: aluOut = fwdA << shamt;
            4'b0101: aluOut = {{(WIDTH-1){1'b0}}, $signed(fwdA) < $signed(srcB)};
            4'b0110: aluOut = fwdA ^ srcB;
            4'b0111: aluOut = fwdA >> shamt;
            4'b1000: aluOut = $unsigned($signed(fwdA) >>> shamt);
            4'b1001: aluOut = {{(WIDTH-1){1'b0}}, fwdA < srcB};
            default: aluOut = '0;
        endcase
    end

    // Branches compare the two forwarded register operands, never the immediate.
    assign eq = fwdA == fwdB;
    assign lt = $signed(fwdA) < $signed(fwdB);
    assign ltu = fwdA < fwdB;
    assign cond = Funct3E[2:1] == 2'b01 ? 1'b0 : (Funct3E[2:1] == 2'b00 ? eq : Funct3E[1] ? ltu : lt) ^ Funct3E[0];
    assign PCSrcE = !stallE && ((BranchE && cond) || JumpE);
    assign PCTargetE = PCE + ImmExtE;

    assign isMdE = ALUControlE inside {[4'b1010:4'b1110]};
    assign isMulE = ALUControlE == 4'b1010;
    assign isSigned = ALUControlE == 4'b1011 || ALUControlE == 4'b1101;
    assign absA = isSigned && fwdA[WIDTH-1] ? -fwdA : fwdA;
    assign absB = isSigned && srcB[WIDTH-1] ? -srcB : srcB;
    assign start = state == IDLE && isMdE && !KillE;

    // One iteration: mul = LSB-first shift-add; div = restoring step with opB shifting the
    // dividend out at the top and quotient bits in at the bottom.
    assign mulSum = acc + (opB[0] ? opA : '0);
    assign remShift = {acc, opB[WIDTH-1]};
    assign remDiff = remShift - {1'b0, opA};
    assign geq = !remDiff[WIDTH];
    assign accN = mdOp == 4'b1010 ? mulSum : geq ? remDiff[WIDTH-1:0] : remShift[WIDTH-1:0];
    assign opAN = mdOp == 4'b1010 ? opA << 1 : opA;
    assign opBN = mdOp == 4'b1010 ? opB >> 1 : {opB[WIDTH-2:0], geq};
    // DONE applies the final iteration combinationally, so registered steps + 1 = WIDTH.
    assign quot = divZero ? '1 : negQ ? -opBN : opBN;
    assign remv = negR ? -accN : accN;
    assign mdOut = mdOp == 4'b1010 ? accN : mdOp inside {4'b1011, 4'b1100} ? quot :
                   mdOp inside {4'b1101, 4'b1110} ? remv : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        stallE = 1'b0;
        if (KillE)
            nextState = IDLE;
        else
            case (state)
                IDLE: begin
                    nextState = isMdE ? BUSY : IDLE;
                    stallE = isMdE && rst;
                end
                BUSY: begin
                    nextState = cnt == CW'(WIDTH - 2) ? DONE : BUSY;
                    stallE = 1'b1;
                end
                default: nextState = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            opA <= '0;
            opB <= '0;
            acc <= '0;
            mdOp <= '0;
            negQ <= 1'b0;
            negR <= 1'b0;
            divZero <= 1'b0;
        end else if (start) begin
            cnt <= '0;
            acc <= '0;
            mdOp <= ALUControlE;
            opA <= isMulE ? fwdA : absB;
            opB <= isMulE ? srcB : absA;
            negQ <= isSigned && (fwdA[WIDTH-1] ^ srcB[WIDTH-1]);
            negR <= isSigned && fwdA[WIDTH-1];
            divZero <= srcB == '0;
        end else if (state == BUSY) begin
            cnt <= cnt + CW'(1);
            opA <= opAN;
            opB <= opBN;
            acc <= accN;
        end
    end

    assign bubble = KillE || stallE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            exMem.RegWriteM <= 1'b0;
            exMem.MemWriteM <= 1'b0;
            exMem.ResultSrcM <= 1'b0;
            exMem.ALUResultM <= '0;
            exMem.WriteDataM <= '0;
            exMem.PCPlus4M <= '0;
            exMem.RdM <= '0;
        end else begin
            exMem.RegWriteM <= RegWriteE && !bubble;
            exMem.MemWriteM <= MemWriteE && !bubble;
            exMem.ResultSrcM <= ResultSrcE && !bubble;
            exMem.ALUResultM <= bubble ? '0 : state == DONE ? mdOut : aluOut;
            exMem.WriteDataM <= bubble ? '0 : fwdB;
            exMem.PCPlus4M <= bubble ? '0 : PCPlus4E;
            exMem.RdM <= bubble ? '0 : RdE;
        end
    end
endmodule
